bp_train_queue: RTL and testbench
=================================

// Module: bp_train_queue
// PURPOSE
//  In-order 2-wide queue of fetch-time predictions, sitting between fetch and the gshare predictor's training port.
//  Matches each resolved instruction against the prediction made for it.
//  Drives the predictor's train_* interface as the initiator and raises a one-cycle mispredict flush with the correct PC.
// PARAMETERS
//  DEPTH  16  queue entries; must be a power of 2, >=4
//  AW     32  address width
// PORTS
//  clk               in   1   clock
//  rst               in   1   reset, synchronous, active-high
//  enq_valid0/1      in   1   fetch slot 0/1 pushes a record; valid1 only legal with valid0
//  enq_pc0/1         in   AW  fetched PC
//  enq_pred0/1       in   AW  predicted next PC (predictor target0/1)
//  enq_ready         out  1   1 when free entries >= 2
//  res_valid0/1      in   1   oldest 1/2 instructions resolved; valid1 only legal with valid0
//  res_isbranch0/1   in   1   resolved instruction is a branch/jump
//  res_taken0/1      in   1   actual direction (ignored if !isbranch)
//  res_target0/1     in   AW  actual branch target
//  train_valid0/1    out  1   training strobe to predictor
//  isbranch0/1       out  1   forwarded res_isbranch
//  address_branch0/1 out  AW  PC of trained instruction (from queue)
//  address_result0/1 out  AW  res_target
//  taken0/1          out  1   res_isbranch & res_taken
//  flush_valid       out  1   one-cycle mispredict pulse
//  flush_pc          out  AW  correct next PC
//  count             out  log2(DEPTH)+1  occupied entries
//  err_underflow     out  1   sticky: resolve arrived with too few entries
// BEHAVIOUR
//  - Reset: head=tail=0, count=0, every output 0 except enq_ready=1; entry storage is not cleared.
//  - Circular buffer with head and tail pointers of log2(DEPTH)+1 bits; the MSB is the wrap bit.
//    full = (ptrs equal except MSB); empty = (ptrs equal).
//  - Enqueue: slot0 is written at tail and slot1 at tail+1; tail advances by 1 or 2.
//    Enqueue while !enq_ready is dropped with no state change.
//  - Resolve: entries are popped at head (slot0 = head, slot1 = head+1).
//    actual_next = (isbranch & taken) ? res_target : pc+4.
//    mispredict = (actual_next != pred).
//  - Training outputs are registered with 1-cycle latency from res_valid.
//    train_valid0 = res_valid0 for one cycle.
//    train_valid1 = res_valid1 & !mispredict0; slot1 is on the wrong path after a slot0 mispredict.
//  - Mispredict: flush_valid=1 for the next cycle only; flush_pc = actual_next of the oldest mispredicting slot.
//    Mispredict also clears the queue: head=tail, count=0 the next cycle.
//    Any enqueue in the mispredict cycle is dropped as wrong path.
//  - Without a mispredict, head advances by the number of valid resolves. Simultaneous enqueue and resolve are both applied.
//    count_next = count + enq_n - res_n.
//  - Underflow: res_valid with count < required entries -> the whole resolve is ignored, no training, err_underflow set until rst.
//  - rst mid-operation: all pointers and outputs return to reset values in the next cycle; a pending flush/training strobe is cancelled.
//  - Illegal valid1 without valid0, on either side: treated as no request. A simulation assertion fires.
//  - Wrap-around: pointer increments modulo 2*DEPTH; an index of ptr[log2(DEPTH)-1:0] wraps naturally.
// STRUCTURE
//  - Shared package bp_pkg holds:
//    - INSN_BYTES=4.
//    - typedef bp_rec_t {pc, pred}.
//    - PTR_W function.
//  - One sub-module, bp_train_ring: dual-write/dual-read circular storage plus head/tail/count logic.
//    The top level holds the compare logic, the training registers and the flush logic.
// TESTING
//  - Reset, enqueue (pc=0x100, pred=0x104), resolve non-branch:
//    next cycle train_valid0=1, isbranch0=0, address_branch0=0x100, flush_valid=0, count=0.
//  - Enqueue (0x200, pred 0x300), resolve taken to 0x300:
//    train_valid0=1, taken0=1, address_result0=0x300, no flush.
//  - Dual enqueue (0x400, pred 0x404)/(0x404, pred 0x408), resolve slot0 taken to 0x800:
//    flush_valid=1, flush_pc=0x800, train_valid1=0, count=0 next cycle.
//  - Fill to DEPTH-1:
//    enq_ready=0, further enqueue dropped, count stays 15.
//    Drain two per cycle across the wrap point: FIFO order is preserved.
//  - Resolve on an empty queue:
//    no train_valid, err_underflow=1 and stays high until rst.
//  - Assert rst during a mispredict cycle:
//    flush_valid=0, train_valid0/1=0, count=0, enq_ready=1 next cycle.

Source files
------------

// File: rtl/bp_train_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bp_pkg                                                          |
// | Brief    : Shared types and helpers for the branch-prediction train queue. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package bp_pkg;

    localparam int INSN_BYTES = 4;
    localparam int c_AW       = 32;

    typedef struct packed {
        logic [c_AW-1:0] pc;
        logic [c_AW-1:0] pred;
    } bp_rec_t;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_train_queue_ring.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bp_train_ring                                                   |
// | Brief    : Dual-write/dual-read circular record store with head/tail ptrs. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bp_train_ring
    import bp_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                push_n,
    input  logic [AW-1:0]             wr_pc0,
    input  logic [AW-1:0]             wr_pred0,
    input  logic [AW-1:0]             wr_pc1,
    input  logic [AW-1:0]             wr_pred1,
    input  logic [1:0]                pop_n,
    input  logic                      clear,
    output logic [AW-1:0]             rd_pc0,
    output logic [AW-1:0]             rd_pred0,
    output logic [AW-1:0]             rd_pc1,
    output logic [AW-1:0]             rd_pred1,
    output logic [ptr_w(DEPTH)-1:0]   count
);

    localparam int c_PW = ptr_w(DEPTH);
    localparam int c_IW = c_PW - 1;

    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_IW-1:0] w_head_idx1;
    logic [c_IW-1:0] w_tail_idx1;
    logic [AW-1:0]   r_pc_mem   [DEPTH];
    logic [AW-1:0]   r_pred_mem [DEPTH];

    assign w_head_idx1 = r_head[c_IW-1:0] + 1'b1;
    assign w_tail_idx1 = r_tail[c_IW-1:0] + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_tail <= r_tail + c_PW'(push_n);
            // A clear collapses the queue onto the current tail.
            if (clear) begin
                r_head <= r_tail;
            end else begin
                r_head <= r_head + c_PW'(pop_n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_n != 2'd0) begin
            r_pc_mem[r_tail[c_IW-1:0]]   <= wr_pc0;
            r_pred_mem[r_tail[c_IW-1:0]] <= wr_pred0;
        end
        if (push_n == 2'd2) begin
            r_pc_mem[w_tail_idx1]   <= wr_pc1;
            r_pred_mem[w_tail_idx1] <= wr_pred1;
        end
    end

    assign rd_pc0   = r_pc_mem[r_head[c_IW-1:0]];
    assign rd_pred0 = r_pred_mem[r_head[c_IW-1:0]];
    assign rd_pc1   = r_pc_mem[w_head_idx1];
    assign rd_pred1 = r_pred_mem[w_head_idx1];
    assign count    = r_tail - r_head;

endmodule
`default_nettype wire

// File: rtl/bp_train_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bp_train_queue                                                  |
// | Brief    : 2-wide in-order prediction queue feeding gshare training/flush. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bp_train_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid0,
    input  logic                     enq_valid1,
    input  logic [AW-1:0]            enq_pc0,
    input  logic [AW-1:0]            enq_pc1,
    input  logic [AW-1:0]            enq_pred0,
    input  logic [AW-1:0]            enq_pred1,
    output logic                     enq_ready,
    input  logic                     res_valid0,
    input  logic                     res_valid1,
    input  logic                     res_isbranch0,
    input  logic                     res_isbranch1,
    input  logic                     res_taken0,
    input  logic                     res_taken1,
    input  logic [AW-1:0]            res_target0,
    input  logic [AW-1:0]            res_target1,
    output logic                     train_valid0,
    output logic                     train_valid1,
    output logic                     isbranch0,
    output logic                     isbranch1,
    output logic [AW-1:0]            address_branch0,
    output logic [AW-1:0]            address_branch1,
    output logic [AW-1:0]            address_result0,
    output logic [AW-1:0]            address_result1,
    output logic                     taken0,
    output logic                     taken1,
    output logic                     flush_valid,
    output logic [AW-1:0]            flush_pc,
    output logic [ptr_w(DEPTH)-1:0]  count,
    output logic                     err_underflow
);

    localparam int c_PW = ptr_w(DEPTH);

    logic [1:0]    w_enq_n;
    logic [1:0]    w_res_req;
    logic [1:0]    w_res_n;
    logic [1:0]    w_push_n;
    logic [1:0]    w_pop_n;
    logic          w_underflow;
    logic          w_rv0;
    logic          w_rv1;
    logic          w_mis0;
    logic          w_mis1;
    logic          w_mispredict;
    logic [AW-1:0] w_q_pc0;
    logic [AW-1:0] w_q_pred0;
    logic [AW-1:0] w_q_pc1;
    logic [AW-1:0] w_q_pred1;
    logic [AW-1:0] w_act0;
    logic [AW-1:0] w_act1;

    logic          r_train_valid0;
    logic          r_train_valid1;
    logic          r_isbranch0;
    logic          r_isbranch1;
    logic [AW-1:0] r_address_branch0;
    logic [AW-1:0] r_address_branch1;
    logic [AW-1:0] r_address_result0;
    logic [AW-1:0] r_address_result1;
    logic          r_taken0;
    logic          r_taken1;
    logic          r_flush_valid;
    logic [AW-1:0] r_flush_pc;
    logic          r_err_underflow;

    // A lone valid1 without valid0 is not a request at all.
    assign w_enq_n   = !enq_valid0 ? 2'd0 : (enq_valid1 ? 2'd2 : 2'd1);
    assign w_res_req = !res_valid0 ? 2'd0 : (res_valid1 ? 2'd2 : 2'd1);

    assign enq_ready   = (count <= c_PW'(DEPTH - 2));
    assign w_underflow = ({{(c_PW-2){1'b0}}, w_res_req} > count);
    assign w_res_n     = w_underflow ? 2'd0 : w_res_req;
    assign w_rv0       = (w_res_n != 2'd0);
    assign w_rv1       = (w_res_n == 2'd2);

    assign w_act0 = (res_isbranch0 && res_taken0) ? res_target0 : w_q_pc0 + AW'(INSN_BYTES);
    assign w_act1 = (res_isbranch1 && res_taken1) ? res_target1 : w_q_pc1 + AW'(INSN_BYTES);

    assign w_mis0       = w_rv0 && (w_act0 != w_q_pred0);
    assign w_mis1       = w_rv1 && (w_act1 != w_q_pred1);
    assign w_mispredict = w_mis0 || w_mis1;

    // Fetch in a mispredict cycle is on the wrong path, so it is discarded.
    assign w_push_n = (enq_ready && !w_mispredict) ? w_enq_n : 2'd0;
    assign w_pop_n  = w_mispredict ? 2'd0 : w_res_n;

    bp_train_ring #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .push_n   (w_push_n),
        .wr_pc0   (enq_pc0),
        .wr_pred0 (enq_pred0),
        .wr_pc1   (enq_pc1),
        .wr_pred1 (enq_pred1),
        .pop_n    (w_pop_n),
        .clear    (w_mispredict),
        .rd_pc0   (w_q_pc0),
        .rd_pred0 (w_q_pred0),
        .rd_pc1   (w_q_pc1),
        .rd_pred1 (w_q_pred1),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_train_valid0    <= 1'b0;
            r_train_valid1    <= 1'b0;
            r_isbranch0       <= 1'b0;
            r_isbranch1       <= 1'b0;
            r_address_branch0 <= '0;
            r_address_branch1 <= '0;
            r_address_result0 <= '0;
            r_address_result1 <= '0;
            r_taken0          <= 1'b0;
            r_taken1          <= 1'b0;
            r_flush_valid     <= 1'b0;
            r_flush_pc        <= '0;
            r_err_underflow   <= 1'b0;
        end else begin
            r_train_valid0 <= w_rv0;
            r_train_valid1 <= w_rv1 && !w_mis0;
            if (w_rv0) begin
                r_isbranch0       <= res_isbranch0;
                r_address_branch0 <= w_q_pc0;
                r_address_result0 <= res_target0;
                r_taken0          <= res_isbranch0 && res_taken0;
            end
            if (w_rv1) begin
                r_isbranch1       <= res_isbranch1;
                r_address_branch1 <= w_q_pc1;
                r_address_result1 <= res_target1;
                r_taken1          <= res_isbranch1 && res_taken1;
            end
            r_flush_valid <= w_mispredict;
            if (w_mispredict) begin
                r_flush_pc <= w_mis0 ? w_act0 : w_act1;
            end
            if (w_underflow) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    assign train_valid0    = r_train_valid0;
    assign train_valid1    = r_train_valid1;
    assign isbranch0       = r_isbranch0;
    assign isbranch1       = r_isbranch1;
    assign address_branch0 = r_address_branch0;
    assign address_branch1 = r_address_branch1;
    assign address_result0 = r_address_result0;
    assign address_result1 = r_address_result1;
    assign taken0          = r_taken0;
    assign taken1          = r_taken1;
    assign flush_valid     = r_flush_valid;
    assign flush_pc        = r_flush_pc;
    assign err_underflow   = r_err_underflow;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(enq_valid1 && !enq_valid0));
            assert (!(res_valid1 && !res_valid0));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_train_queue.sv
`default_nettype none
// Randomized scoreboard bench for bp_train_queue against a queue-level reference model.
module tb_bp_train_queue;
    import bp_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 32;
    localparam int PW    = ptr_w(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          enq_valid0, enq_valid1;
    logic [AW-1:0] enq_pc0, enq_pc1, enq_pred0, enq_pred1;
    logic          enq_ready;
    logic          res_valid0, res_valid1;
    logic          res_isbranch0, res_isbranch1, res_taken0, res_taken1;
    logic [AW-1:0] res_target0, res_target1;
    logic          train_valid0, train_valid1, isbranch0, isbranch1, taken0, taken1;
    logic [AW-1:0] address_branch0, address_branch1, address_result0, address_result1;
    logic          flush_valid;
    logic [AW-1:0] flush_pc;
    logic [PW-1:0] count;
    logic          err_underflow;

    bp_train_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .enq_valid0(enq_valid0), .enq_valid1(enq_valid1),
        .enq_pc0(enq_pc0), .enq_pc1(enq_pc1),
        .enq_pred0(enq_pred0), .enq_pred1(enq_pred1),
        .enq_ready(enq_ready),
        .res_valid0(res_valid0), .res_valid1(res_valid1),
        .res_isbranch0(res_isbranch0), .res_isbranch1(res_isbranch1),
        .res_taken0(res_taken0), .res_taken1(res_taken1),
        .res_target0(res_target0), .res_target1(res_target1),
        .train_valid0(train_valid0), .train_valid1(train_valid1),
        .isbranch0(isbranch0), .isbranch1(isbranch1),
        .address_branch0(address_branch0), .address_branch1(address_branch1),
        .address_result0(address_result0), .address_result1(address_result1),
        .taken0(taken0), .taken1(taken1),
        .flush_valid(flush_valid), .flush_pc(flush_pc),
        .count(count), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            edge_no;
        bit            tv1;
        bit            isb0, tk0, isb1, tk1, fl;
        logic [AW-1:0] ab0, ar0, ab1, ar1, fpc;
    } exp_t;

    bp_rec_t model_q[$];
    exp_t    exp_q[$];
    bit      m_err;
    int      edge_cnt = 0;
    int      n_pass = 0;
    int      n_total = 0;
    exp_t    mon_e;

    always @(posedge clk) edge_cnt++;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s @edge %0d: got 0x%0h, required 0x%0h", name, edge_cnt, act, req);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = $urandom;
        a[1:0] = 2'b00;
        return a;
    endfunction

    // Reference model: called with the inputs the DUT samples at the next edge.
    function automatic void model_step();
        int            ne, nr, cnt;
        bit            rdy, mis;
        exp_t          e;
        logic [AW-1:0] act;
        bp_rec_t       r;
        if (rst) begin
            model_q.delete();
            m_err = 1'b0;
            return;
        end
        ne  = enq_valid0 ? (enq_valid1 ? 2 : 1) : 0;
        nr  = res_valid0 ? (res_valid1 ? 2 : 1) : 0;
        cnt = model_q.size();
        rdy = (DEPTH - cnt) >= 2;
        if (nr > cnt) begin
            m_err = 1'b1;
            nr = 0;
        end
        mis = 1'b0;
        if (nr > 0) begin
            e = '{default: 0};
            e.edge_no = edge_cnt + 1;
            e.isb0 = res_isbranch0;
            e.tk0  = res_isbranch0 & res_taken0;
            e.ab0  = model_q[0].pc;
            e.ar0  = res_target0;
            act = e.tk0 ? res_target0 : model_q[0].pc + INSN_BYTES;
            if (act != model_q[0].pred) begin
                mis = 1'b1; e.fl = 1'b1; e.fpc = act;
            end
            if (nr == 2 && !mis) begin
                e.tv1  = 1'b1;
                e.isb1 = res_isbranch1;
                e.tk1  = res_isbranch1 & res_taken1;
                e.ab1  = model_q[1].pc;
                e.ar1  = res_target1;
                act = e.tk1 ? res_target1 : model_q[1].pc + INSN_BYTES;
                if (act != model_q[1].pred) begin
                    mis = 1'b1; e.fl = 1'b1; e.fpc = act;
                end
            end
            exp_q.push_back(e);
        end
        if (mis) begin
            model_q.delete();
        end else begin
            repeat (nr) void'(model_q.pop_front());
            if (rdy && ne >= 1) begin
                r.pc = enq_pc0; r.pred = enq_pred0; model_q.push_back(r);
            end
            if (rdy && ne == 2) begin
                r.pc = enq_pc1; r.pred = enq_pred1; model_q.push_back(r);
            end
        end
    endfunction

    task automatic apply();
        model_step();
        @(posedge clk);
        #1;
        enq_valid0 = 1'b0; enq_valid1 = 1'b0;
        res_valid0 = 1'b0; res_valid1 = 1'b0;
        rst = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 64'(count), 64'(model_q.size()));
        chk({tag, "_enq_ready"}, 64'(enq_ready), 64'((DEPTH - model_q.size()) >= 2));
        chk({tag, "_err"}, 64'(err_underflow), 64'(m_err));
    endtask

    task automatic gen_outcome(input bp_rec_t rec, output logic isb, output logic tk,
                               output logic [AW-1:0] tgt);
        int r;
        r = $urandom_range(0, 9);
        if (rec.pred == rec.pc + INSN_BYTES) begin
            if (r < 5)      begin isb = 1'b0; tk = 1'($urandom_range(0, 1)); tgt = rand_addr(); end
            else if (r < 8) begin isb = 1'b1; tk = 1'b0; tgt = rand_addr(); end
            else            begin isb = 1'b1; tk = 1'b1; tgt = rand_addr(); end
        end else begin
            if (r < 8)      begin isb = 1'b1; tk = 1'b1; tgt = rec.pred; end
            else if (r < 9) begin isb = 1'b0; tk = 1'b1; tgt = rec.pred; end
            else            begin isb = 1'b1; tk = 1'b0; tgt = rec.pred; end
        end
    endtask

    // Monitor: every training/flush presentation must match the oldest due expectation.
    always @(negedge clk) begin
        if (train_valid0 || train_valid1 || flush_valid) begin
            if (exp_q.size() == 0 || exp_q[0].edge_no != edge_cnt) begin
                n_total++;
                $display("FAIL unexpected_train @edge %0d: tv0=%0b tv1=%0b flush=%0b, required none",
                         edge_cnt, train_valid0, train_valid1, flush_valid);
                if (exp_q.size() != 0 && exp_q[0].edge_no < edge_cnt) void'(exp_q.pop_front());
            end else begin
                mon_e = exp_q.pop_front();
                chk("tv0", 64'(train_valid0), 64'(1));
                chk("tv1", 64'(train_valid1), 64'(mon_e.tv1));
                chk("isb0", 64'(isbranch0), 64'(mon_e.isb0));
                chk("ab0", 64'(address_branch0), 64'(mon_e.ab0));
                chk("ar0", 64'(address_result0), 64'(mon_e.ar0));
                chk("tk0", 64'(taken0), 64'(mon_e.tk0));
                if (mon_e.tv1) begin
                    chk("isb1", 64'(isbranch1), 64'(mon_e.isb1));
                    chk("ab1", 64'(address_branch1), 64'(mon_e.ab1));
                    chk("ar1", 64'(address_result1), 64'(mon_e.ar1));
                    chk("tk1", 64'(taken1), 64'(mon_e.tk1));
                end
                chk("flush_valid", 64'(flush_valid), 64'(mon_e.fl));
                if (mon_e.fl) chk("flush_pc", 64'(flush_pc), 64'(mon_e.fpc));
            end
        end else if (exp_q.size() != 0 && exp_q[0].edge_no <= edge_cnt) begin
            n_total++;
            $display("FAIL missing_train @edge %0d: tv0=0, required tv0=1", edge_cnt);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        rst = 1'b1;
        enq_valid0 = 0; enq_valid1 = 0; enq_pc0 = 0; enq_pc1 = 0; enq_pred0 = 0; enq_pred1 = 0;
        res_valid0 = 0; res_valid1 = 0; res_isbranch0 = 0; res_isbranch1 = 0;
        res_taken0 = 0; res_taken1 = 0; res_target0 = 0; res_target1 = 0;
        m_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_enq_ready", 64'(enq_ready), 64'(1));
        chk("rst_tv0", 64'(train_valid0), 64'(0));
        chk("rst_tv1", 64'(train_valid1), 64'(0));
        chk("rst_flush", 64'(flush_valid), 64'(0));
        chk("rst_err", 64'(err_underflow), 64'(0));
        rst = 1'b0;

        // Non-branch resolve
        enq_valid0 = 1; enq_pc0 = 32'h100; enq_pred0 = 32'h104; apply();
        res_valid0 = 1; res_isbranch0 = 0; res_taken0 = 0; res_target0 = 0; apply();
        chk("t1_tv0", 64'(train_valid0), 64'(1));
        chk("t1_isb0", 64'(isbranch0), 64'(0));
        chk("t1_ab0", 64'(address_branch0), 64'h100);
        chk("t1_flush", 64'(flush_valid), 64'(0));
        chk("t1_count", 64'(count), 64'(0));

        // Correctly predicted taken branch
        enq_valid0 = 1; enq_pc0 = 32'h200; enq_pred0 = 32'h300; apply();
        res_valid0 = 1; res_isbranch0 = 1; res_taken0 = 1; res_target0 = 32'h300; apply();
        chk("t2_tv0", 64'(train_valid0), 64'(1));
        chk("t2_tk0", 64'(taken0), 64'(1));
        chk("t2_ar0", 64'(address_result0), 64'h300);
        chk("t2_flush", 64'(flush_valid), 64'(0));

        // Slot0 mispredict kills slot1 training and clears the queue
        enq_valid0 = 1; enq_valid1 = 1;
        enq_pc0 = 32'h400; enq_pred0 = 32'h404; enq_pc1 = 32'h404; enq_pred1 = 32'h408; apply();
        res_valid0 = 1; res_valid1 = 1;
        res_isbranch0 = 1; res_taken0 = 1; res_target0 = 32'h800;
        res_isbranch1 = 0; res_taken1 = 0; res_target1 = 0; apply();
        chk("t3_flush", 64'(flush_valid), 64'(1));
        chk("t3_flush_pc", 64'(flush_pc), 64'h800);
        chk("t3_tv1", 64'(train_valid1), 64'(0));
        chk("t3_count", 64'(count), 64'(0));

        // Fill to DEPTH-1 across the wrap point, then drain in order
        for (int i = 0; i < 7; i++) begin
            enq_valid0 = 1; enq_valid1 = 1;
            enq_pc0 = 32'h1000 + 32'(i * 8); enq_pred0 = enq_pc0 + 4;
            enq_pc1 = enq_pc0 + 4;           enq_pred1 = enq_pc1 + 4;
            apply();
        end
        enq_valid0 = 1; enq_pc0 = 32'h1038; enq_pred0 = 32'h103C; apply();
        chk("t4_enq_ready", 64'(enq_ready), 64'(0));
        chk("t4_count", 64'(count), 64'(DEPTH - 1));
        enq_valid0 = 1; enq_valid1 = 1; enq_pc0 = 32'hDEAD0; enq_pc1 = 32'hDEAD4; apply();
        chk("t4_drop_count", 64'(count), 64'(DEPTH - 1));
        for (int i = 0; i < 8; i++) begin
            res_valid0 = 1; res_valid1 = (i < 7);
            res_isbranch0 = 0; res_taken0 = 0; res_target0 = 32'h5555_0000;
            res_isbranch1 = 0; res_taken1 = 1; res_target1 = 32'h6666_0000;
            apply();
            check_state("t4_drain");
        end

        // Underflow on an empty queue is sticky
        res_valid0 = 1; res_isbranch0 = 1; res_taken0 = 1; res_target0 = 32'h40; apply();
        chk("t5_tv0", 64'(train_valid0), 64'(0));
        chk("t5_err", 64'(err_underflow), 64'(1));
        repeat (3) apply();
        chk("t5_err_sticky", 64'(err_underflow), 64'(1));

        // Reset in the mispredict cycle cancels everything
        enq_valid0 = 1; enq_pc0 = 32'h500; enq_pred0 = 32'h504; apply();
        res_valid0 = 1; res_isbranch0 = 1; res_taken0 = 1; res_target0 = 32'h900;
        rst = 1; apply();
        chk("t6_flush", 64'(flush_valid), 64'(0));
        chk("t6_tv0", 64'(train_valid0), 64'(0));
        chk("t6_tv1", 64'(train_valid1), 64'(0));
        chk("t6_count", 64'(count), 64'(0));
        chk("t6_enq_ready", 64'(enq_ready), 64'(1));
        chk("t6_err", 64'(err_underflow), 64'(0));

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int nr;
            enq_valid0 = ($urandom_range(0, 99) < 60);
            enq_valid1 = enq_valid0 && ($urandom_range(0, 1) == 1);
            enq_pc0   = rand_addr();
            enq_pred0 = ($urandom_range(0, 9) < 7) ? enq_pc0 + 4 : rand_addr();
            enq_pc1   = enq_pred0;
            enq_pred1 = ($urandom_range(0, 9) < 7) ? enq_pc1 + 4 : rand_addr();
            nr = $urandom_range(0, 2);
            if (nr > model_q.size()) nr = model_q.size();
            res_valid0 = (nr >= 1);
            res_valid1 = (nr == 2);
            res_isbranch0 = 1'($urandom_range(0, 1)); res_taken0 = 1'($urandom_range(0, 1));
            res_isbranch1 = 1'($urandom_range(0, 1)); res_taken1 = 1'($urandom_range(0, 1));
            res_target0 = rand_addr(); res_target1 = rand_addr();
            if (nr >= 1) gen_outcome(model_q[0], res_isbranch0, res_taken0, res_target0);
            if (nr == 2) gen_outcome(model_q[1], res_isbranch1, res_taken1, res_target1);
            rst = ($urandom_range(0, 199) == 0);
            apply();
            check_state("rand");
        end

        repeat (4) apply();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
